lc3b_mem_responder: RTL



---
 rtl/lc3b_mem_responder_if.sv | 34 +++
 rtl/lc3b_mem_responder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_responder_if.sv
// LC-3b memory bus between the datapath/control initiator and the memory responder.
// The initiator drives requests and the responder returns data, completion and error.
interface lc3b_mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        mem_error;

    modport master (
        output mem_read,
        output mem_write,
        output mem_byte_enable,
        output mem_address,
        output mem_wdata,
        input  mem_rdata,
        input  mem_resp,
        input  mem_error
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_byte_enable,
        input  mem_address,
        input  mem_wdata,
        output mem_rdata,
        output mem_resp,
        output mem_error
    );
endinterface

// File: rtl/lc3b_mem_responder.sv
// LC-3b word-organised memory responder with fixed latency and a one-cycle mem_resp.
// Define LC3B_MEM_RANDLAT_EN to add 0..3 LFSR-chosen wait cycles per transaction.
module lc3b_mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 3
) (
    input logic                 clk,
    input logic                 reset,
    lc3b_mem_responder_if.slave mem
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic                resp_q, resp_d;
    logic [15:0]         rdata_q, rdata_d;
    logic [15:0]         mem_q [DEPTH];

    logic                req;
    logic [ADDR_BITS-1:0] waddr;
    logic [4:0]          lat_eff;
    logic                commit;
    logic [15:0]         old_word;
    logic [15:0]         merged;
    logic                addr_unused;

    assign req   = mem.mem_read | mem.mem_write;
    assign waddr = mem.mem_address[ADDR_BITS:1];

    // Byte offset and high address bits alias onto the same word.
    assign addr_unused = ^{mem.mem_address[0], mem.mem_address[15:ADDR_BITS+1]};

`ifdef LC3B_MEM_RANDLAT_EN
    logic [7:0] lfsr_q, lfsr_d;

    assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign lat_eff = 5'(LATENCY) + {3'b000, lfsr_q[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign lat_eff = 5'(LATENCY);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    // A read+write conflict is serviced as a write.
                    wr_d  = mem.mem_write;
                    err_d = err_q | (mem.mem_read & mem.mem_write);
                    if (lat_eff == 5'd1) begin
                        state_d = RESP;
                        cnt_d   = 5'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = lat_eff - 5'd1;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                end else if (cnt_q <= 5'd1) begin
                    state_d = RESP;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        endcase
        if (state_d == RESP && !wr_d) begin
            rdata_d = mem_q[waddr];
        end
    end

    assign resp_d = (state_d == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    // Writes land on the edge leaving RESP, only if the request is still held.
    assign commit   = (state_q == RESP) && wr_q && req && !reset;
    assign old_word = mem_q[waddr];
    assign merged   = {
        mem.mem_byte_enable[1] ? mem.mem_wdata[15:8] : old_word[15:8],
        mem.mem_byte_enable[0] ? mem.mem_wdata[7:0]  : old_word[7:0]
    };

    always_ff @(posedge clk) begin
        if (commit) begin
            mem_q[waddr] <= merged;
        end
    end

    assign mem.mem_rdata = rdata_q;
    assign mem.mem_resp  = resp_q;
    assign mem.mem_error = err_q;
endmodule
